// File: rtl/count_seq_checker.sv
// Monitor for a WIDTH-bit up/down counter: predicts each step from the previous
// sample, locks after LOCK_LEN good steps and tallies illegal steps while locked.
module count_seq_checker #(
    parameter int WIDTH    = 3,
    parameter int LOCK_LEN = 4,
    parameter int ERR_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cnt_rst,
    input  logic             mode,
    input  logic [WIDTH-1:0] count,
    input  logic             clr_err,
    output logic             locked,
    output logic             mismatch,
    output logic [WIDTH-1:0] expected,
    output logic             dir,
    output logic [ERR_W-1:0] err_count
);

    localparam int RUN_W = 4;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [RUN_W-1:0]   run_reg;
    logic [WIDTH-1:0]   prev_count_reg;
    logic               prev_mode_reg;

    logic [WIDTH-1:0]   predicted;
    logic               step_ok;
    logic [RUN_W-1:0]   run_next;
    logic               err_full;

    // Natural WIDTH-bit wrap gives the legal 7->0 and 0->7 transitions.
    function automatic logic [WIDTH-1:0] step_of(input logic [WIDTH-1:0] c, input logic m);
        return m ? (c - WIDTH'(1)) : (c + WIDTH'(1));
    endfunction

    assign predicted = step_of(prev_count_reg, prev_mode_reg);
    assign step_ok   = (count == predicted);
    assign run_next  = run_reg + RUN_W'(1);
    assign err_full  = &err_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ACQUIRE;
            run_reg        <= '0;
            prev_count_reg <= '0;
            prev_mode_reg  <= 1'b0;
            locked         <= 1'b0;
            mismatch       <= 1'b0;
            expected       <= '0;
            dir            <= 1'b0;
            err_count      <= '0;
        end else begin
            mismatch <= 1'b0;
            if (clr_err) begin
                err_count <= '0;
            end

            if (cnt_rst) begin
                // Counter is being reset: drop lock, keep the error tally and history.
                state_reg <= ACQUIRE;
                run_reg   <= '0;
                locked    <= 1'b0;
                expected  <= '0;
            end else begin
                prev_count_reg <= count;
                prev_mode_reg  <= mode;
                expected       <= step_of(count, mode);

                case (state_reg)
                    ACQUIRE: begin
                        state_reg <= TRACK;
                        run_reg   <= '0;
                    end
                    TRACK: begin
                        if (step_ok) begin
                            dir     <= prev_mode_reg;
                            run_reg <= run_next;
                            if (run_next == RUN_W'(LOCK_LEN)) begin
                                state_reg <= LOCKED;
                                locked    <= 1'b1;
                            end
                        end else begin
                            run_reg <= '0;
                        end
                    end
                    LOCKED: begin
                        if (step_ok) begin
                            dir <= prev_mode_reg;
                        end else begin
                            mismatch  <= 1'b1;
                            state_reg <= TRACK;
                            run_reg   <= '0;
                            locked    <= 1'b0;
                            // A coincident clear takes priority over the increment.
                            if (!clr_err && !err_full) begin
                                err_count <= err_count + ERR_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_reg <= ACQUIRE;
                        run_reg   <= '0;
                        locked    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_seq_checker.sv
// Randomized and directed bench for count_seq_checker against a behavioural model.
module tb_count_seq_checker;

    localparam int WIDTH    = 3;
    localparam int LOCK_LEN = 4;
    localparam int ERR_W    = 4;
    localparam int MOD      = 1 << WIDTH;
    localparam int MAXE     = (1 << ERR_W) - 1;
    localparam int VW       = 2 + WIDTH + 1 + ERR_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             cnt_rst;
    logic             mode;
    logic [WIDTH-1:0] count;
    logic             clr_err;
    logic             locked;
    logic             mismatch;
    logic [WIDTH-1:0] expected;
    logic             dir;
    logic [ERR_W-1:0] err_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: history of the stream in plain integers.
    bit m_have;
    int m_prev_c;
    bit m_prev_m;
    int m_run;
    bit m_locked;
    bit m_mis;
    bit m_dir;
    int m_err;
    int m_exp;
    int cur;

    count_seq_checker #(.WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cnt_rst   (cnt_rst),
        .mode      (mode),
        .count     (count),
        .clr_err   (clr_err),
        .locked    (locked),
        .mismatch  (mismatch),
        .expected  (expected),
        .dir       (dir),
        .err_count (err_count)
    );

    always #10 clk = ~clk;

    function automatic int next_of(input int c, input bit m);
        return m ? (c + MOD - 1) % MOD : (c + 1) % MOD;
    endfunction

    function automatic logic [VW-1:0] obs();
        return {locked, mismatch, expected, dir, err_count};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [WIDTH-1:0] e;
        logic [ERR_W-1:0] er;
        e  = WIDTH'(m_exp);
        er = ERR_W'(m_err);
        return {m_locked, m_mis, e, m_dir, er};
    endfunction

    task automatic model_reset();
        m_have = 0; m_prev_c = 0; m_prev_m = 0; m_run = 0;
        m_locked = 0; m_mis = 0; m_dir = 0; m_err = 0; m_exp = 0;
    endtask

    task automatic model_edge(input int c, input bit m, input bit cr, input bit ce);
        bit ok;
        m_mis = 0;
        if (ce) m_err = 0;
        if (cr) begin
            m_have = 0; m_run = 0; m_locked = 0; m_exp = 0;
        end else begin
            if (m_have) begin
                ok = (c == next_of(m_prev_c, m_prev_m));
                if (ok) begin
                    m_dir = m_prev_m;
                    if (!m_locked) begin
                        m_run++;
                        if (m_run >= LOCK_LEN) m_locked = 1;
                    end
                end else begin
                    if (m_locked) begin
                        m_mis = 1;
                        if (!ce && m_err < MAXE) m_err++;
                    end
                    m_locked = 0;
                    m_run = 0;
                end
            end
            m_have = 1; m_prev_c = c; m_prev_m = m; m_exp = next_of(c, m);
        end
    endtask

    // One clock of stimulus: inputs change on the falling edge, outputs read 1 ns after rising.
    task automatic drive(input int c, input bit m, input bit cr, input bit ce);
        @(negedge clk);
        count = WIDTH'(c); mode = m; cnt_rst = cr; clr_err = ce;
        @(posedge clk);
        model_edge(c, m, cr, ce);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; cnt_rst = 1'b0; mode = 1'b0; count = '0; clr_err = 1'b0;
        model_reset();
        #5;
        n_checks++;
        if (obs() !== '0) $display("FAIL reset_t5: got %b want %b", obs(), {VW{1'b0}});
        else n_pass++;
        #7;
        n_checks++;
        if (obs() !== '0) $display("FAIL reset_after_edge: got %b want %b", obs(), {VW{1'b0}});
        else n_pass++;
        #3;
        reset = 1'b1;
    endtask

    task automatic test_up_lock_wrap();
        for (int i = 0; i < 14; i++) begin
            cur = i % MOD;
            drive(cur, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs() !== model_vec()) $display("FAIL up_lock[%0d]: got %b want %b", i, obs(), model_vec());
            else n_pass++;
            n_checks++;
            if (expected !== WIDTH'((i + 1) % MOD) || locked !== (i >= 4) || mismatch !== 1'b0)
                $display("FAIL up_lock_direct[%0d]: got exp=%0d lock=%b mis=%b want exp=%0d lock=%b mis=0",
                         i, expected, locked, mismatch, (i + 1) % MOD, (i >= 4));
            else n_pass++;
        end
    endtask

    task automatic test_dir_change();
        int seq[3] = '{6, 5, 4};
        for (int i = 0; i < 3; i++) begin
            cur = seq[i];
            drive(cur, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (obs() !== model_vec()) $display("FAIL dir_change[%0d]: got %b want %b", i, obs(), model_vec());
            else n_pass++;
            n_checks++;
            if (dir !== (i > 0) || locked !== 1'b1 || mismatch !== 1'b0)
                $display("FAIL dir_direct[%0d]: got dir=%b lock=%b mis=%b want dir=%b lock=1 mis=0",
                         i, dir, locked, mismatch, (i > 0));
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        int seq[4] = '{7, 0, 1, 2};
        cur = 6;
        drive(cur, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (mismatch !== 1'b1 || err_count !== ERR_W'(1) || locked !== 1'b0 || obs() !== model_vec())
            $display("FAIL glitch: got %b want %b (mis=1 err=1 lock=0)", obs(), model_vec());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            cur = seq[i];
            drive(cur, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs() !== model_vec() || locked !== (i == 3))
                $display("FAIL glitch_relock[%0d]: got %b want %b", i, obs(), model_vec());
            else n_pass++;
        end
    endtask

    task automatic glitch_and_relock(input bit ce, input string tag);
        cur = (cur + 4) % MOD;
        drive(cur, 1'b0, 1'b0, ce);
        n_checks++;
        if (mismatch !== 1'b1 || obs() !== model_vec())
            $display("FAIL %s_pulse: got %b want %b", tag, obs(), model_vec());
        else n_pass++;
        for (int j = 0; j < LOCK_LEN; j++) begin
            cur = (cur + 1) % MOD;
            drive(cur, 1'b0, 1'b0, 1'b0);
        end
        n_checks++;
        if (locked !== 1'b1 || obs() !== model_vec())
            $display("FAIL %s_relock: got %b want %b", tag, obs(), model_vec());
        else n_pass++;
    endtask

    task automatic test_saturation_clear();
        for (int k = 0; k < 17; k++) glitch_and_relock(1'b0, "sat");
        n_checks++;
        if (err_count !== ERR_W'(MAXE)) $display("FAIL sat_hold: got %0d want %0d", err_count, MAXE);
        else n_pass++;
        cur = (cur + 1) % MOD;
        drive(cur, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (err_count !== '0 || obs() !== model_vec())
            $display("FAIL clr_alone: got %b want %b", obs(), model_vec());
        else n_pass++;
        glitch_and_relock(1'b0, "pre_clr");
        glitch_and_relock(1'b1, "clr_with_mis");
        n_checks++;
        if (err_count !== '0) $display("FAIL clr_wins: got %0d want 0", err_count);
        else n_pass++;
    endtask

    task automatic test_cnt_rst();
        logic [ERR_W-1:0] err_before;
        while (cur != 5) begin
            cur = (cur + 1) % MOD;
            drive(cur, 1'b0, 1'b0, 1'b0);
        end
        glitch_and_relock(1'b0, "cr_prep");
        while (cur != 5) begin
            cur = (cur + 1) % MOD;
            drive(cur, 1'b0, 1'b0, 1'b0);
        end
        err_before = err_count;
        cur = 0;
        drive(cur, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (locked !== 1'b0 || mismatch !== 1'b0 || err_count !== err_before || obs() !== model_vec())
            $display("FAIL cnt_rst: got %b want %b", obs(), model_vec());
        else n_pass++;
        for (int i = 0; i <= LOCK_LEN; i++) begin
            cur = i;
            drive(cur, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs() !== model_vec() || locked !== (i == LOCK_LEN))
                $display("FAIL cnt_rst_relock[%0d]: got %b want %b", i, obs(), model_vec());
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (obs() !== '0) $display("FAIL async_reset: got %b want %b", obs(), {VW{1'b0}});
        else n_pass++;
        #2;
        reset = 1'b1;
        cur = 3;
        drive(cur, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs() !== model_vec() || expected !== WIDTH'(2) || locked !== 1'b0)
            $display("FAIL async_first_capture: got %b want %b", obs(), model_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        bit m = 1'b1;
        bit cr, ce;
        int c, r;
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 99);
            c  = next_of(cur, m);
            cr = 1'b0;
            if (r < 4) begin
                cr = 1'b1; c = 0;
            end else if (r < 12) begin
                c = (c + $urandom_range(1, MOD - 1)) % MOD;
            end
            ce = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 7) == 0) m = ~m;
            cur = c;
            drive(c, m, cr, ce);
            n_checks++;
            if (obs() !== model_vec())
                $display("FAIL random[%0d]: got %b want %b (count=%0d mode=%b cr=%b clr=%b)",
                         i, obs(), model_vec(), c, m, cr, ce);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_up_lock_wrap();
        test_dir_change();
        test_glitch();
        test_saturation_clear();
        test_cnt_rst();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
